// File: rtl/hasti_arbiter.sv
// Round-robin arbiter sharing one HASTI (AHB-lite) slave among NUM_MASTERS masters.
// Ownership moves only when the current owner is IDLE, unlocked and the slave is ready.

module hasti_arbiter_lane #(
  parameter int IW  = 1,
  parameter int IDX = 0
) (
  input  logic [IW-1:0] owner,
  input  logic [1:0]    htrans,
  input  logic          s_hready,
  output logic          hready,
  output logic          req
);
  assign hready = s_hready && (owner == IW'(IDX));
  assign req    = (htrans == 2'b10) && (owner != IW'(IDX));
endmodule

module hasti_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_MASTERS*AW-1:0]      m_haddr,
  input  logic [NUM_MASTERS-1:0]         m_hwrite,
  input  logic [NUM_MASTERS*3-1:0]       m_hsize,
  input  logic [NUM_MASTERS*3-1:0]       m_hburst,
  input  logic [NUM_MASTERS-1:0]         m_hmastlock,
  input  logic [NUM_MASTERS*4-1:0]       m_hprot,
  input  logic [NUM_MASTERS*2-1:0]       m_htrans,
  input  logic [NUM_MASTERS*DW-1:0]      m_hwdata,
  output logic [NUM_MASTERS-1:0]         m_hready,
  output logic [DW-1:0]                  m_hrdata,
  output logic                           m_hresp,
  output logic [AW-1:0]                  s_haddr,
  output logic                           s_hwrite,
  output logic [2:0]                     s_hsize,
  output logic [2:0]                     s_hburst,
  output logic                           s_hmastlock,
  output logic [3:0]                     s_hprot,
  output logic [1:0]                     s_htrans,
  output logic [DW-1:0]                  s_hwdata,
  input  logic [DW-1:0]                  s_hrdata,
  input  logic                           s_hready,
  input  logic                           s_hresp,
  output logic [$clog2(NUM_MASTERS)-1:0] hmaster
);
  localparam int IW = $clog2(NUM_MASTERS);

  logic [IW-1:0]          addr_owner, data_owner, sel, nxt_owner;
  logic [NUM_MASTERS-1:0] req;
  logic                   found, sw;
  int                     cand;

  // Master 0 is passed through while reset is held.
  assign sel = reset ? '0 : addr_owner;

  assign s_haddr     = m_haddr[sel*AW +: AW];
  assign s_hwrite    = m_hwrite[sel];
  assign s_hsize     = m_hsize[sel*3 +: 3];
  assign s_hburst    = m_hburst[sel*3 +: 3];
  assign s_hmastlock = m_hmastlock[sel];
  assign s_hprot     = m_hprot[sel*4 +: 4];
  assign s_htrans    = m_htrans[sel*2 +: 2];
  assign s_hwdata    = m_hwdata[data_owner*DW +: DW];

  assign m_hrdata = s_hrdata;
  assign m_hresp  = s_hresp;
  assign hmaster  = addr_owner;

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_lane
    hasti_arbiter_lane #(.IW(IW), .IDX(g)) u_lane (
      .owner    (addr_owner),
      .htrans   (m_htrans[g*2 +: 2]),
      .s_hready (s_hready),
      .hready   (m_hready[g]),
      .req      (req[g])
    );
  end

  // Search starts just after the current owner so every requester gets a turn.
  always_comb begin
    found     = 1'b0;
    nxt_owner = addr_owner;
    cand      = 0;
    for (int k = 1; k < NUM_MASTERS; k++) begin
      cand = (int'(addr_owner) + k) % NUM_MASTERS;
      if (!found && req[cand]) begin
        found     = 1'b1;
        nxt_owner = IW'(cand);
      end
    end
  end

  assign sw = (m_htrans[addr_owner*2 +: 2] == 2'b00) && !m_hmastlock[addr_owner] && found;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_owner <= '0;
      data_owner <= '0;
    end else if (s_hready) begin
      data_owner <= addr_owner;
      if (sw) addr_owner <= nxt_owner;
    end
  end
endmodule
